// File: rtl/popcount_stream_checker.sv
// Streaming population-count checker.
// Each accepted word yields its popcount plus onehot/onehot0 flags through an
// elastic pipeline of STAGES register slices. A saturating per-frame sum of
// set bits is published on acc_count when the last beat of a frame leaves.
module popcount_stream_checker #(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 2,
    parameter int ACC_WIDTH = 16,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_count,
    output logic                 out_onehot,
    output logic                 out_onehot0,
    output logic                 out_last,
    output logic [ACC_WIDTH-1:0] acc_count,
    output logic                 acc_valid,
    output logic                 acc_sat
);

    // Per-beat payload carried down the pipe: {last, onehot0, onehot, count}.
    localparam int PW = CW + 3;
    // Sum width wide enough that running + count can never wrap.
    localparam int SW = ((ACC_WIDTH > CW) ? ACC_WIDTH : CW) + 1;
    localparam logic [SW-1:0] ACC_MAX = {{(SW - ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    logic [CW-1:0]              word_count;
    logic [PW-1:0]              in_payload;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES-1:0]          stage_load;
    logic [STAGES-1:0][PW-1:0]  stage_data;

    // Count the set bits of the incoming word; flags follow from the count.
    always_comb begin
        word_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_count = word_count + CW'(in_data[i]);
        end
        in_payload = {in_last, (word_count <= CW'(1)), (word_count == CW'(1)), word_count};
    end

    // Load enables ripple back from out_ready: a slice may load when it is
    // empty or when its current occupant moves on in the same cycle.
    always_comb begin
        logic ready_chain;
        ready_chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            stage_load[i] = !stage_valid[i] || ready_chain;
            ready_chain   = stage_load[i];
        end
    end

    assign in_ready = stage_load[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
            logic          valid_reg;
            logic [PW-1:0] data_reg;
            logic          up_valid;
            logic [PW-1:0] up_data;

            if (gi == 0) begin : gen_head
                assign up_valid = in_valid;
                assign up_data  = in_payload;
            end else begin : gen_body
                assign up_valid = stage_valid[gi-1];
                assign up_data  = stage_data[gi-1];
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;

            // Slice register: take the upstream beat whenever this slice may load.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (stage_load[gi]) begin
                    valid_reg <= up_valid;
                    if (up_valid) begin
                        data_reg <= up_data;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stage_valid[STAGES-1];
    assign {out_last, out_onehot0, out_onehot, out_count} = stage_data[STAGES-1];

    logic                 out_fire;
    logic [ACC_WIDTH-1:0] run_sum_reg;
    logic                 frame_sat_reg;
    logic [ACC_WIDTH-1:0] acc_count_reg;
    logic                 acc_sat_reg;
    logic                 acc_valid_reg;
    logic [SW-1:0]        sum_wide;
    logic                 sum_sat;
    logic [ACC_WIDTH-1:0] sum_next;

    assign out_fire = out_valid && out_ready;

    // Saturating add of the departing beat's count onto the frame total.
    always_comb begin
        sum_wide = SW'(run_sum_reg) + SW'(out_count);
        sum_sat  = (sum_wide > ACC_MAX);
        sum_next = sum_sat ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
    end

    // Frame accumulator: fold in each departing beat, publish on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sum_reg   <= '0;
            frame_sat_reg <= 1'b0;
            acc_count_reg <= '0;
            acc_sat_reg   <= 1'b0;
            acc_valid_reg <= 1'b0;
        end else begin
            acc_valid_reg <= 1'b0;
            if (out_fire) begin
                if (out_last) begin
                    acc_count_reg <= sum_next;
                    acc_sat_reg   <= frame_sat_reg | sum_sat;
                    acc_valid_reg <= 1'b1;
                    run_sum_reg   <= '0;
                    frame_sat_reg <= 1'b0;
                end else begin
                    run_sum_reg   <= sum_next;
                    frame_sat_reg <= frame_sat_reg | sum_sat;
                end
            end
        end
    end

    assign acc_count = acc_count_reg;
    assign acc_sat   = acc_sat_reg;
    assign acc_valid = acc_valid_reg;

endmodule

// File: doc/popcount_stream_checker.md
Name: popcount_stream_checker

Overview:
- Streaming, parametrised successor to the combinational $countones/$onehot/$onehot0 checks.
- Accepts WIDTH-bit words over a valid/ready handshake and returns, per word and after STAGES cycles, the population count plus onehot and onehot0 flags.
- Accumulates a saturating per-frame total of set bits, with frames delimited by in_last.
- Sits between a data source and status/CSR logic that needs bit-density and one-hot-legality statistics.

Parameters:
- WIDTH, 16, input word width; must be >= 1.
- STAGES, 2, pipeline depth and latency in cycles; must be >= 1.
- ACC_WIDTH, 16, width of the frame accumulator; must be >= 1.
- CW (localparam), $clog2(WIDTH+1), width of the per-word count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  word to analyse.
- in_last  in  1  beat is the final beat of its frame.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_count  out  CW  number of 1 bits in the word.
- out_onehot  out  1  exactly one bit set.
- out_onehot0  out  1  zero or one bit set.
- out_last  out  1  in_last carried with the beat.
- acc_count  out  ACC_WIDTH  saturated frame total, held until the next frame completes.
- acc_valid  out  1  one-cycle pulse when acc_count updates.
- acc_sat  out  1  total of the last completed frame saturated.

Behaviour:
- Reset: all stage valid bits clear. Running sum = 0. out_valid, acc_valid, acc_sat = 0. acc_count = 0. out_count/out_onehot/out_onehot0/out_last = 0. in_ready = 1 during and after reset.
- Reset is asynchronous at any time. In-flight beats and a partial frame sum are discarded, and no acc_valid is produced for them.
- Input handshake: a beat transfers on a rising edge with in_valid && in_ready. in_data/in_last are sampled only then.
- Output handshake: a beat leaves on a rising edge with out_valid && out_ready.
- While out_valid && !out_ready, all out_* signals hold stable.
- Pipeline: STAGES registered stages forming an elastic pipeline. Each stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !stage0_valid || stage0 advances. It is combinational from out_ready through the chain.
  - Full throughput of 1 beat/cycle with out_ready held at 1.
  - Holds up to STAGES beats under backpressure, with no loss or reorder.
- Latency: a beat accepted at edge N presents out_valid in the cycle after edge N+STAGES-1, i.e. STAGES cycles, when unstalled.
- Arithmetic: out_count = number of 1 bits in the word, in range 0..WIDTH.
  - out_onehot = (count == 1); out_onehot0 = (count <= 1).
  - For WIDTH = 1: onehot = bit, onehot0 = 1.
  - Split points across stages are implementation-free; all outputs come from registers.
- Accumulator: updates only on an output handshake, with sum_next = min(running + out_count, 2^ACC_WIDTH-1).
  - The saturation flag is sticky within the frame.
  - On a handshake with out_last = 1, at the next edge:
    - acc_count = sum_next;
    - acc_sat = frame saturation flag, including this beat;
    - acc_valid = 1 for exactly one cycle;
    - running sum and flag clear to 0.
  - A single-beat frame (in_last on the first beat) is legal.
  - Back-to-back last beats produce back-to-back acc_valid pulses.
- Boundaries:
  - An all-zero word counts 0 and does not break a frame.
  - An all-ones word counts WIDTH.
  - Pipeline full with out_ready = 0 gives in_ready = 0. When out_ready rises, in_ready rises in the same cycle.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1; send 8'hAA, 8'h00, 8'h08, 8'hFF on consecutive cycles -> outputs at +2 cycles, one per cycle:
  - count 4, onehot 0, onehot0 0
  - count 0, onehot 0, onehot0 1
  - count 1, onehot 1, onehot0 1
  - count 8, onehot 0, onehot0 0
- Frame AA, F0, 08(last) -> a single acc_valid pulse one cycle after the last output handshake, acc_count=9, acc_sat=0. Next frame 01(last) -> acc_count=1.
- Backpressure: out_ready=0, in_valid=1 streaming 01,03,07,0F -> in_ready drops after 2 accepted beats. out_count holds at 1 while stalled. Raising out_ready yields 1,2,3,4 in order, with no gaps once flowing.
- Saturation: ACC_WIDTH=4, frame FF, FF, FF(last) -> acc_count=15, acc_sat=1. Following frame 03(last) -> acc_count=2, acc_sat=0.
- Reset mid-operation: assert rst_n=0 asynchronously mid-frame with 2 beats in flight -> out_valid=0 immediately, with no acc_valid. After release, frame 0F(last) -> acc_count=4.
- WIDTH=1, STAGES=1: send 1, 0 -> count 1/onehot 1/onehot0 1, then count 0/onehot 0/onehot0 1, each with latency 1.
